// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
//   Shared definitions for the PWM capture block and its sibling generator /
//   divider blocks.
//   - pwm_state_e     : capture FSM states (idle, measuring high, measuring low)
//   - DefaultCntWidth : default width of the high/period counters
//   - MaxDivision     : largest legal prescale exponent
//   - tick_mask()     : prescaler bit mask selecting the tick rate
// ---------------------------------------------------------------------------
package pwm_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHigh = 2'd1,
        StLow  = 2'd2
    } pwm_state_e;

    localparam int unsigned DefaultCntWidth = 16;
    localparam int unsigned MaxDivision     = 8;

    // Mask of the low prescaler bits that must all be ones for a tick.
    // A value of 0 yields an empty mask, so every cycle ticks. Out-of-range
    // values fall back to a divide-by-2 rate.
    function automatic logic [7:0] tick_mask(input logic [7:0] division_value);
        logic [3:0] n;
        logic [8:0] full;
        if (division_value > 8'(MaxDivision)) begin
            n = 4'd1;
        end else begin
            n = division_value[3:0];
        end
        full = (9'd1 << n) - 9'd1;
        return full[7:0];
    endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// ---------------------------------------------------------------------------
// pwm_capture_if
//   Control, input and result signals of the PWM capture block.
//   master : driven by the register wrapper / environment
//            (enable, clear, division_value, pwm_in out; results in)
//   slave  : the capture block itself
//            (controls and pwm_in in; high_count, period_count,
//             result_valid, overflow out)
// ---------------------------------------------------------------------------
interface pwm_capture_if
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = DefaultCntWidth
) ();

    logic                 enable;
    logic                 clear;
    logic [7:0]           division_value;
    logic                 pwm_in;
    logic [CNT_WIDTH-1:0] high_count;
    logic [CNT_WIDTH-1:0] period_count;
    logic                 result_valid;
    logic                 overflow;

    modport master (
        output enable,
        output clear,
        output division_value,
        output pwm_in,
        input  high_count,
        input  period_count,
        input  result_valid,
        input  overflow
    );

    modport slave (
        input  enable,
        input  clear,
        input  division_value,
        input  pwm_in,
        output high_count,
        output period_count,
        output result_valid,
        output overflow
    );

endinterface

// File: rtl/pwm_input_sync.sv
// ---------------------------------------------------------------------------
// pwm_input_sync
//   Brings the asynchronous PWM pin into the clock domain and detects edges.
//   Ports:
//     clock_in : system clock, rising edge
//     reset    : asynchronous, active-high
//     pwm_in   : raw asynchronous PWM pin
//     level    : synchronized level
//     rise     : level went 0 -> 1 this cycle
//     fall     : level went 1 -> 0 this cycle
//   All outputs are 0 while in reset.
// ---------------------------------------------------------------------------
module pwm_input_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock_in,
    input  logic reset,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_dly_q;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            level_dly_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            level_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~level_dly_q;
    assign fall  = ~level & level_dly_q;

endmodule

// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//   Measures the high time and the period of an incoming PWM waveform in
//   prescaled clock ticks and reports each complete period with a one-cycle
//   result_valid strobe.
//   Ports:
//     clock_in : system clock, rising edge
//     reset    : asynchronous, active-high; clears all state
//     bus      : pwm_capture_if.slave
//                enable, clear, division_value, pwm_in (in)
//                high_count, period_count, result_valid, overflow (out)
// ---------------------------------------------------------------------------
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = DefaultCntWidth,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clock_in,
    input  logic           reset,
    pwm_capture_if.slave   bus
);

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    // Synchronized input and edges
    logic level;
    logic rise;
    logic fall;

    pwm_input_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock_in(clock_in),
        .reset   (reset),
        .pwm_in  (bus.pwm_in),
        .level   (level),
        .rise    (rise),
        .fall    (fall)
    );

    // Free-running prescaler; never cleared by enable or clear so the tick
    // phase only depends on time since reset.
    logic [7:0] presc_q;
    logic [7:0] presc_mask;
    logic       tick;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            presc_q <= 8'd0;
        end else begin
            presc_q <= presc_q + 8'd1;
        end
    end

    assign presc_mask = tick_mask(bus.division_value);
    assign tick       = (presc_q & presc_mask) == presc_mask;

    // Measurement state
    pwm_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_WIDTH-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_WIDTH-1:0] hi_tmp_q, hi_tmp_d;
    logic [CNT_WIDTH-1:0] high_count_q, high_count_d;
    logic [CNT_WIDTH-1:0] period_count_q, period_count_d;
    logic                 result_valid_q, result_valid_d;
    logic                 overflow_q, overflow_d;

    // Counter helpers: an edge restarts at 1 if the edge cycle itself ticks,
    // otherwise counting advances one per tick and sticks at the maximum.
    logic [CNT_WIDTH-1:0] load_val;
    logic [CNT_WIDTH-1:0] hi_inc;
    logic [CNT_WIDTH-1:0] per_inc;
    logic                 hi_sat;
    logic                 per_sat;

    assign load_val = CNT_WIDTH'(tick);
    assign hi_sat   = hi_cnt_q == CntMax;
    assign per_sat  = per_cnt_q == CntMax;
    assign hi_inc   = (tick && !hi_sat) ? hi_cnt_q + CNT_WIDTH'(1) : hi_cnt_q;
    assign per_inc  = (tick && !per_sat) ? per_cnt_q + CNT_WIDTH'(1) : per_cnt_q;

    always_comb begin
        state_d        = state_q;
        hi_cnt_d       = hi_cnt_q;
        per_cnt_d      = per_cnt_q;
        hi_tmp_d       = hi_tmp_q;
        high_count_d   = high_count_q;
        period_count_d = period_count_q;
        result_valid_d = 1'b0;
        overflow_d     = overflow_q;

        if (bus.clear) begin
            // Clear wins over any edge seen in the same cycle.
            state_d        = StIdle;
            hi_cnt_d       = '0;
            per_cnt_d      = '0;
            hi_tmp_d       = '0;
            high_count_d   = '0;
            period_count_d = '0;
            overflow_d     = 1'b0;
        end else if (!bus.enable) begin
            // Abandon the measurement but keep the last results visible.
            state_d   = StIdle;
            hi_cnt_d  = '0;
            per_cnt_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    hi_cnt_d  = '0;
                    per_cnt_d = '0;
                    if (rise) begin
                        state_d   = StHigh;
                        hi_cnt_d  = load_val;
                        per_cnt_d = load_val;
                    end
                end

                StHigh: begin
                    if (fall) begin
                        hi_tmp_d  = hi_cnt_q;
                        per_cnt_d = per_inc;
                        state_d   = StLow;
                    end else if (hi_sat || per_sat) begin
                        // 100% duty or a high phase longer than the counter.
                        overflow_d = 1'b1;
                        state_d    = StIdle;
                        hi_cnt_d   = '0;
                        per_cnt_d  = '0;
                    end else begin
                        hi_cnt_d  = hi_inc;
                        per_cnt_d = per_inc;
                    end
                end

                StLow: begin
                    if (rise) begin
                        high_count_d   = hi_tmp_q;
                        period_count_d = per_cnt_q;
                        result_valid_d = 1'b1;
                        hi_cnt_d       = load_val;
                        per_cnt_d      = load_val;
                        state_d        = StHigh;
                    end else if (per_sat) begin
                        // 0% duty or a period longer than the counter.
                        overflow_d = 1'b1;
                        state_d    = StIdle;
                        hi_cnt_d   = '0;
                        per_cnt_d  = '0;
                    end else begin
                        per_cnt_d = per_inc;
                    end
                end

                default: begin
                    state_d   = StIdle;
                    hi_cnt_d  = '0;
                    per_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            hi_cnt_q       <= '0;
            per_cnt_q      <= '0;
            hi_tmp_q       <= '0;
            high_count_q   <= '0;
            period_count_q <= '0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            hi_cnt_q       <= hi_cnt_d;
            per_cnt_q      <= per_cnt_d;
            hi_tmp_q       <= hi_tmp_d;
            high_count_q   <= high_count_d;
            period_count_q <= period_count_d;
            result_valid_q <= result_valid_d;
            overflow_q     <= overflow_d;
        end
    end

    assign bus.high_count   = high_count_q;
    assign bus.period_count = period_count_q;
    assign bus.result_valid = result_valid_q;
    assign bus.overflow     = overflow_q;

    // A result needs a full high and low phase, so strobes cannot be adjacent.
    assert property (@(posedge clock_in) disable iff (reset) result_valid_q |=> !result_valid_q);
    // Edges derive from the synchronized level.
    assert property (@(posedge clock_in) disable iff (reset) rise |-> level);

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;
    import pwm_pkg::*;

    typedef struct {
        int unsigned div;
        int unsigned hi;
        int unsigned lo;
        int unsigned reps;
        int unsigned n_valid;
        int unsigned exp_hi;
        int unsigned exp_per;
    } vec_t;

    logic       clock_in = 1'b0;
    logic       reset    = 1'b0;
    logic       en       = 1'b0;
    logic       clr      = 1'b0;
    logic       pwm      = 1'b0;
    logic [7:0] div      = 8'd0;

    always #5 clock_in = ~clock_in;

    pwm_capture_if #(.CNT_WIDTH(16)) bus ();
    pwm_capture_if #(.CNT_WIDTH(8))  bus8 ();

    assign bus.enable          = en;
    assign bus.clear           = clr;
    assign bus.division_value  = div;
    assign bus.pwm_in          = pwm;
    assign bus8.enable         = en;
    assign bus8.clear          = clr;
    assign bus8.division_value = div;
    assign bus8.pwm_in         = pwm;

    pwm_capture #(.CNT_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clock_in(clock_in),
        .reset   (reset),
        .bus     (bus.slave)
    );

    pwm_capture #(.CNT_WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .clock_in(clock_in),
        .reset   (reset),
        .bus     (bus8.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model, index 0 = 16-bit DUT, index 1 = 8-bit DUT.
    // Counts are differences of a cumulative tick total between edge times.
    longint maxv [2] = '{65535, 255};
    bit     armed [2];
    bit     lowph [2];
    bit     e_valid [2];
    bit     e_ov [2];
    longint rise_t [2];
    longint hi_val [2];
    longint e_high [2];
    longint e_per [2];
    longint tcum;
    longint pc;
    bit     h1, h2, h3;  // pwm driven 1, 2, 3 cycles ago

    int     vcount;
    int     v8count;
    longint last_hi;
    longint last_per;

    function automatic void check(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic longint cap(longint v, longint m);
        return (v > m) ? m : v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            armed[k] = 0; lowph[k] = 0; e_valid[k] = 0; e_ov[k] = 0;
            rise_t[k] = 0; hi_val[k] = 0; e_high[k] = 0; e_per[k] = 0;
        end
        tcum = 0; pc = 0; h1 = 0; h2 = 0; h3 = 0;
    endtask

    // One clock cycle: advance the model with the inputs held this cycle,
    // clock the DUTs, then compare every output.
    task automatic cycle();
        bit     s, sp, rise, fall, tk;
        longint m, run;
        s    = h2;
        sp   = h3;
        rise = s && !sp;
        fall = !s && sp;
        m    = (div == 0) ? 0 : ((div > 8) ? 1 : longint'(div));
        tk   = (pc % (64'd1 << m)) == ((64'd1 << m) - 1);
        for (int k = 0; k < 2; k++) begin
            e_valid[k] = 0;
            run = tcum - rise_t[k];
            if (clr) begin
                armed[k] = 0; e_high[k] = 0; e_per[k] = 0; e_ov[k] = 0;
            end else if (!en) begin
                armed[k] = 0;
            end else if (!armed[k]) begin
                if (rise) begin armed[k] = 1; lowph[k] = 0; rise_t[k] = tcum; end
            end else if (!lowph[k]) begin
                if (fall) begin lowph[k] = 1; hi_val[k] = cap(run, maxv[k]); end
                else if (run >= maxv[k]) begin e_ov[k] = 1; armed[k] = 0; end
            end else begin
                if (rise) begin
                    e_valid[k] = 1;
                    e_high[k]  = hi_val[k];
                    e_per[k]   = cap(run, maxv[k]);
                    rise_t[k]  = tcum;
                    lowph[k]   = 0;
                end else if (run >= maxv[k]) begin
                    e_ov[k] = 1; armed[k] = 0;
                end
            end
        end
        tcum += longint'(tk);
        h3 = h2; h2 = h1; h1 = pwm;
        @(posedge clock_in);
        pc++;
        #1;
        if (bus.result_valid) begin
            vcount++;
            last_hi  = longint'(bus.high_count);
            last_per = longint'(bus.period_count);
        end
        if (bus8.result_valid) v8count++;
        check("valid16", longint'(bus.result_valid), longint'(e_valid[0]));
        check("high16", longint'(bus.high_count), e_high[0]);
        check("per16", longint'(bus.period_count), e_per[0]);
        check("ovf16", longint'(bus.overflow), longint'(e_ov[0]));
        check("valid8", longint'(bus8.result_valid), longint'(e_valid[1]));
        check("high8", longint'(bus8.high_count), e_high[1]);
        check("per8", longint'(bus8.period_count), e_per[1]);
        check("ovf8", longint'(bus8.overflow), longint'(e_ov[1]));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_valid", longint'(bus.result_valid), 0);
        check("rst_high", longint'(bus.high_count), 0);
        check("rst_per", longint'(bus.period_count), 0);
        check("rst_ovf", longint'(bus.overflow), 0);
        @(posedge clock_in);
        #2;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic run_wave(int unsigned hi, int unsigned lo, int unsigned reps);
        for (int r = 0; r < int'(reps); r++) begin
            pwm = 1'b1;
            repeat (hi) cycle();
            pwm = 1'b0;
            repeat (lo) cycle();
        end
    endtask

    task automatic start(logic [7:0] d);
        do_reset();
        div = d; en = 1'b1; clr = 1'b0; pwm = 1'b0;
        repeat (4) cycle();
        vcount = 0; v8count = 0;
    endtask

    initial begin
        vec_t        vecs [5];
        int unsigned r;
        vecs[0] = '{0, 25, 75, 4, 3, 25, 100};
        vecs[1] = '{0, 1, 1, 10, 9, 1, 2};
        vecs[2] = '{0, 10, 30, 3, 2, 10, 40};
        vecs[3] = '{9, 8, 8, 3, 2, 4, 8};
        vecs[4] = '{3, 16, 24, 3, 2, 2, 5};

        #1;
        do_reset();

        for (int i = 0; i < 5; i++) begin
            start(8'(vecs[i].div));
            run_wave(vecs[i].hi, vecs[i].lo, vecs[i].reps);
            repeat (5) cycle();
            check($sformatf("vec%0d_count", i), longint'(vcount), longint'(vecs[i].n_valid));
            check($sformatf("vec%0d_high", i), last_hi, longint'(vecs[i].exp_hi));
            check($sformatf("vec%0d_per", i), last_per, longint'(vecs[i].exp_per));
            check($sformatf("vec%0d_ovf", i), longint'(bus.overflow), 0);
        end

        // Divide by 4: 100-cycle period is exactly 25 ticks, 25-cycle high 6 or 7.
        start(8'd2);
        run_wave(25, 75, 4);
        repeat (5) cycle();
        check("div2_count", longint'(vcount), 3);
        check("div2_per", last_per, 25);
        check("div2_hi_range", longint'(last_hi >= 6 && last_hi <= 7), 1);

        // Stuck-high input saturates the 8-bit counter.
        start(8'd0);
        pwm = 1'b1;
        repeat (250) cycle();
        check("ovf8_early", longint'(bus8.overflow), 0);
        repeat (50) cycle();
        check("ovf8_set", longint'(bus8.overflow), 1);
        check("ovf16_clear", longint'(bus.overflow), 0);
        check("ovf8_no_valid", longint'(v8count), 0);
        clr = 1'b1; cycle(); clr = 1'b0;
        check("ovf8_cleared", longint'(bus8.overflow), 0);

        // Reset in the middle of a low phase.
        start(8'd0);
        run_wave(25, 75, 2);
        pwm = 1'b1; repeat (25) cycle();
        pwm = 1'b0; repeat (30) cycle();
        check("midlow_pre", longint'(vcount), 2);
        do_reset();
        vcount = 0;
        repeat (40) cycle();
        run_wave(25, 75, 1);
        check("rst_one_rise", longint'(vcount), 0);
        run_wave(25, 75, 1);
        check("rst_two_rise", longint'(vcount), 1);
        check("rst_high_after", last_hi, 25);
        check("rst_per_after", last_per, 100);

        // Clear in the same cycle the rise is detected in the low phase.
        start(8'd0);
        run_wave(25, 75, 2);
        pwm = 1'b1;
        cycle(); cycle();
        clr = 1'b1; cycle(); clr = 1'b0;
        check("clr_valid", longint'(bus.result_valid), 0);
        check("clr_high", longint'(bus.high_count), 0);
        check("clr_per", longint'(bus.period_count), 0);
        repeat (22) cycle();
        pwm = 1'b0; repeat (75) cycle();
        check("clr_no_result", longint'(vcount), 1);
        run_wave(25, 75, 2);
        check("clr_next_count", longint'(vcount), 2);
        check("clr_next_high", last_hi, 25);
        check("clr_next_per", last_per, 100);

        // Randomized waveforms with occasional enable drops, clears and stalls.
        start(8'd0);
        for (int seg = 0; seg < 120; seg++) begin
            r = $urandom_range(0, 99);
            if (r < 10) begin
                case ($urandom_range(0, 4))
                    0: div = 8'd0;
                    1: div = 8'd1;
                    2: div = 8'd2;
                    3: div = 8'd3;
                    default: div = 8'd9;
                endcase
            end else if (r < 14) begin
                en = 1'b0;
                repeat ($urandom_range(1, 6)) cycle();
                en = 1'b1;
            end else if (r < 17) begin
                clr = 1'b1; cycle(); clr = 1'b0;
            end else if (r == 17) begin
                div = 8'd0; pwm = 1'b1;
                repeat (300) cycle();
            end
            pwm = 1'b1;
            repeat ($urandom_range(1, 40)) cycle();
            pwm = 1'b0;
            repeat ($urandom_range(1, 40)) cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
